led_scan_driver: RTL

Time-multiplexed driver for an N-digit common-anode 7-segment display, the parametrised successor to the single-digit hex decoder. It accepts a packed vector of 4-bit hex characters plus per-digit blanking from the UART receive path, double-buffers them so a frame is never torn, and scans the digits one at a time. A dead-time gap between digits suppresses ghosting. It sits between the UART data/control logic and the board's segment and anode pins.

---
 rtl/led_pkg.sv | 30 +++
 rtl/led_scan_driver_if.sv | 15 +
 rtl/led_scan_driver_hex_to_7seg.sv | 33 +++
 rtl/led_scan_driver.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants for the 7-segment scan driver: active-high hex glyphs,
// the blank segment pattern and the scan FSM state encoding.
package led_pkg;

  typedef logic [6:0] seg_t;

  // bit0 = a ... bit6 = g, 1 = segment lit
  localparam seg_t GLYPH_0 = 7'h3F;
  localparam seg_t GLYPH_1 = 7'h06;
  localparam seg_t GLYPH_2 = 7'h5B;
  localparam seg_t GLYPH_3 = 7'h4F;
  localparam seg_t GLYPH_4 = 7'h66;
  localparam seg_t GLYPH_5 = 7'h6D;
  localparam seg_t GLYPH_6 = 7'h7D;
  localparam seg_t GLYPH_7 = 7'h07;
  localparam seg_t GLYPH_8 = 7'h7F;
  localparam seg_t GLYPH_9 = 7'h6F;
  localparam seg_t GLYPH_A = 7'h77;
  localparam seg_t GLYPH_B = 7'h7C;
  localparam seg_t GLYPH_C = 7'h39;
  localparam seg_t GLYPH_D = 7'h5E;
  localparam seg_t GLYPH_E = 7'h79;
  localparam seg_t GLYPH_F = 7'h71;

  localparam seg_t SEG_OFF = 7'h00;

  localparam logic [0:0] ST_GAP   = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

endpackage

// File: rtl/led_scan_driver_if.sv
// Display bus between the UART-side control logic (master) and the scan
// driver (slave): character/blank load path plus the pin-level outputs.
interface led_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] chars;
  logic [NUM_DIGITS-1:0]   blank;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (output load, chars, blank, input seg, an, frame_done);
  modport slave  (input load, chars, blank, output seg, an, frame_done);
endinterface

// File: rtl/led_scan_driver_hex_to_7seg.sv
// Combinational hex digit to active-high 7-segment glyph decoder.
module hex_to_7seg
  import led_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // glyph lookup
  always_comb begin
    seg_o = SEG_OFF;
    case (hex_i)
      4'h0:    seg_o = GLYPH_0;
      4'h1:    seg_o = GLYPH_1;
      4'h2:    seg_o = GLYPH_2;
      4'h3:    seg_o = GLYPH_3;
      4'h4:    seg_o = GLYPH_4;
      4'h5:    seg_o = GLYPH_5;
      4'h6:    seg_o = GLYPH_6;
      4'h7:    seg_o = GLYPH_7;
      4'h8:    seg_o = GLYPH_8;
      4'h9:    seg_o = GLYPH_9;
      4'hA:    seg_o = GLYPH_A;
      4'hB:    seg_o = GLYPH_B;
      4'hC:    seg_o = GLYPH_C;
      4'hD:    seg_o = GLYPH_D;
      4'hE:    seg_o = GLYPH_E;
      4'hF:    seg_o = GLYPH_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/led_scan_driver.sv
// Time-multiplexed N-digit 7-segment scanner with double-buffered frame data
// and an all-off dead-time gap between digits.
module led_scan_driver
  import led_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int GAP_CYCLES   = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic               clk,
  input  logic               reset,
  led_scan_driver_if.slave   bus
);

  localparam int MAXC = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic          INVERT   = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_PIN_OFF  = INVERT ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0]            SEG_PIN_OFF = INVERT ? ~SEG_OFF : SEG_OFF;

  logic [0:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    frame_done_q, frame_done_d;
  logic [4*NUM_DIGITS-1:0] sh_chars_q, sh_chars_d, act_chars_q, act_chars_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;

  logic [3:0]              digit_s;
  logic [6:0]              glyph_s;

  assign digit_s = act_chars_q[{idx_q, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .hex_i (digit_s),
    .seg_o (glyph_s)
  );

  // scan sequencing: GAP -> DRIVE -> GAP, advancing the digit on each DRIVE exit
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DIG_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_GAP;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // a load coinciding with the frame boundary skips the shadow stage
  always_comb begin
    if (bus.load) begin
      sh_chars_d = bus.chars;
      sh_blank_d = bus.blank;
    end else begin
      sh_chars_d = sh_chars_q;
      sh_blank_d = sh_blank_q;
    end
    if (frame_done_q) begin
      act_chars_d = sh_chars_d;
      act_blank_d = sh_blank_d;
    end else begin
      act_chars_d = act_chars_q;
      act_blank_d = act_blank_q;
    end
  end

  // pin values for the current state, polarity applied last
  always_comb begin
    logic [NUM_DIGITS-1:0] an_hi;
    logic [6:0]            seg_hi;
    an_hi  = '0;
    seg_hi = SEG_OFF;
    if (state_q == ST_DRIVE) begin
      an_hi = NUM_DIGITS'(1) << idx_q;
      if (act_blank_q[idx_q]) begin
        seg_hi = SEG_OFF;
      end else begin
        seg_hi = glyph_s;
      end
    end else begin
      an_hi  = '0;
      seg_hi = SEG_OFF;
    end
    an_d  = INVERT ? ~an_hi  : an_hi;
    seg_d = INVERT ? ~seg_hi : seg_hi;
  end

  // state, buffers and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_GAP;
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      sh_chars_q   <= '0;
      sh_blank_q   <= '1;
      act_chars_q  <= '0;
      act_blank_q  <= '1;
      an_q         <= AN_PIN_OFF;
      seg_q        <= SEG_PIN_OFF;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      sh_chars_q   <= sh_chars_d;
      sh_blank_q   <= sh_blank_d;
      act_chars_q  <= act_chars_d;
      act_blank_q  <= act_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule
